// File: rtl/bcd_disp_pkg.sv
// Shared types, glyph constants and counter sizing for the two-digit BCD scan display.
package bcd_disp_pkg;

  typedef enum logic {
    UNITS = 1'b0,
    TENS  = 1'b1
  } digit_e;

  // Glyphs are stored active-high as {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam int REFRESH_DIV_DEFAULT = 50000;

  // Refresh counter width, $clog2(REFRESH_DIV), never narrower than one bit
  function automatic int rcnt_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-high seven-segment decoder with a non-decimal flag.
module bcd_to_seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg,
  output logic       invalid
);

  // Glyph lookup; 10..15 are blanked
  always_comb begin
    seg     = SEG_BLANK;
    invalid = (nib > 4'd9);
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Two-digit multiplexed seven-segment driver with ghost guard and nibble error flag.
// Optional build macro LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module bcd_seg_scan
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV    = REFRESH_DIV_DEFAULT,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bcd_in,
  input  logic       load,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       err
);

  localparam int             CW        = rcnt_width(REFRESH_DIV);
  localparam logic [CW-1:0]  RCNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [6:0]     SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [7:0]    disp_r;
  logic [CW-1:0] rcnt_r;
  digit_e        state_r;

  logic [6:0] units_seg_s, tens_seg_s, seg_hi_s, seg_nxt_s;
  logic       units_inv_s, tens_inv_s, wrap_s;
  logic [1:0] an_sel_s, an_nxt_s;

  bcd_to_seg u_units (.nib(disp_r[3:0]), .seg(units_seg_s), .invalid(units_inv_s));
  bcd_to_seg u_tens  (.nib(disp_r[7:4]), .seg(tens_seg_s),  .invalid(tens_inv_s));

  // Next-cycle output selection from the current digit slot
  always_comb begin
    wrap_s   = (rcnt_r == RCNT_LAST);
    seg_hi_s = SEG_BLANK;
    an_sel_s = 2'b11;
    case (state_r)
      UNITS: begin
        seg_hi_s = units_seg_s;
        an_sel_s = 2'b10;
      end
      TENS: begin
        seg_hi_s = tens_seg_s;
`ifdef LEADING_ZERO_BLANK_EN
        if (disp_r[7:4] == 4'h0) begin
          an_sel_s = 2'b11;
        end else begin
          an_sel_s = 2'b01;
        end
`else
        an_sel_s = 2'b01;
`endif
      end
      default: begin
        seg_hi_s = SEG_BLANK;
        an_sel_s = 2'b11;
      end
    endcase
    // Count zero is the ghost-guard cycle: segments switch while both digits are dark
    an_nxt_s  = (rcnt_r == {CW{1'b0}}) ? 2'b11 : an_sel_s;
    seg_nxt_s = SEG_ACTIVE_LOW ? ~seg_hi_s : seg_hi_s;
  end

  // Held BCD word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_r <= 8'h00;
    end else if (load) begin
      disp_r <= bcd_in;
    end else begin
      disp_r <= disp_r;
    end
  end

  // Refresh counter, digit-select FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_r  <= {CW{1'b0}};
      state_r <= UNITS;
      seg     <= SEG_OFF;
      an      <= 2'b11;
      err     <= 1'b0;
    end else begin
      rcnt_r <= wrap_s ? {CW{1'b0}} : rcnt_r + CW'(1);
      if (wrap_s) begin
        state_r <= (state_r == UNITS) ? TENS : UNITS;
      end else begin
        state_r <= state_r;
      end
      seg <= seg_nxt_s;
      an  <= an_nxt_s;
      err <= units_inv_s | tens_inv_s;
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Self-checking bench for bcd_seg_scan: directed scenarios plus random loads against a frame-position model.
module tb_bcd_seg_scan;

  localparam int RD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] bcd_in;
  logic       load;
  logic [6:0] seg;
  logic [1:0] an;
  logic       err;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         n        = 0;
  logic [7:0] held     = 8'h00;

  logic [6:0] glyph_hi [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  bcd_seg_scan #(.REFRESH_DIV(RD), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .load(load),
    .seg(seg), .an(an), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph_al(input logic [3:0] d);
    if (d > 4'd9) return 7'h7F;
    return ~glyph_hi[d];
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, then compare outputs against the frame-position model.
  task automatic step(input logic ld, input logic [7:0] d);
    int         p;
    logic [3:0] nib;
    logic [1:0] ean;
    logic       eerr;
    load   = ld;
    bcd_in = d;
    @(posedge clk);
    #1;
    n++;
    p   = (n - 1) % (2 * RD);
    nib = (p < RD) ? held[3:0] : held[7:4];
    if (p % RD == 0) ean = 2'b11;
    else if (p < RD) ean = 2'b10;
    else ean = 2'b01;
`ifdef LEADING_ZERO_BLANK_EN
    if (p >= RD && held[7:4] == 4'h0) ean = 2'b11;
`endif
    eerr = (held[7:4] > 4'd9) || (held[3:0] > 4'd9);
    check("an",  {5'b0, an},  {5'b0, ean});
    check("seg", seg, glyph_al(nib));
    check("err", {6'b0, err}, {6'b0, eerr});
    if (ld) held = d;
  endtask

  initial begin
    rst_n  = 1'b0;
    load   = 1'b0;
    bcd_in = 8'h00;
    @(posedge clk);
    #1;
    check("rst_an",  {5'b0, an}, 7'h03);
    check("rst_seg", seg, 7'h7F);
    check("rst_err", {6'b0, err}, 7'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle frames of "00"
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00);

    // Load 15 and scan two frames
    step(1'b1, 8'h15);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00);

    // Invalid units nibble, then a valid word clears err
    step(1'b1, 8'h1F);
    step(1'b0, 8'h00);
    check("err_1F", {6'b0, err}, 7'h01);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00);
    step(1'b1, 8'h09);
    step(1'b0, 8'h00);
    check("err_09", {6'b0, err}, 7'h00);

    // Load coinciding with the UNITS->TENS wrap
    step(1'b1, 8'h03);
    while ((n % (2 * RD)) != 3) step(1'b0, 8'h00);
    step(1'b1, 8'h12);
    for (int i = 0; i < RD; i++) begin
      step(1'b0, 8'h00);
      check("wrap_tens_seg", seg, 7'h79);
    end

    // Asynchronous reset mid-slot while showing 14
    step(1'b1, 8'h14);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_an",  {5'b0, an}, 7'h03);
    check("arst_seg", seg, 7'h7F);
    check("arst_err", {6'b0, err}, 7'h00);
    @(negedge clk);
    rst_n = 1'b1;
    n     = 0;
    held  = 8'h00;
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    check("post_rst_seg", seg, 7'h40);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00);

    // Random loads, including non-decimal nibbles
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_seg_scan.md
# bcd_seg_scan

Two-digit, time-multiplexed seven-segment display driver that sits directly downstream of the binary-to-BCD converter. It captures the converter's 8-bit BCD word (tens in [7:4], units in [3:0]) on a load strobe and holds it. It alternately drives the units and tens digits through a shared segment bus at a refresh rate set by a parameter. It also decodes each BCD nibble to segments and flags non-decimal nibbles.

## Interface
- REFRESH_DIV, 50000: clock cycles each digit is in its slot, including its ghost-guard cycle; legal range ≥2.
- SEG_ACTIVE_LOW, 1: 1 means segment outputs are active-low; 0 means active-high.
- clk  input  1  system clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- bcd_in  input  8  BCD word, {tens, units}.
- load  input  1  single-cycle capture strobe; while high, bcd_in is sampled every cycle.
- seg  output  7  segments {g,f,e,d,c,b,a}; polarity set by SEG_ACTIVE_LOW.
- an  output  2  digit enables, active-low; an[0] = units, an[1] = tens.
- err  output  1  high when the held word contains a nibble >9.

## Operation
- Holding register `disp` (8 b):
  - loads bcd_in on any rising edge where load=1;
  - otherwise holds its value.
- Refresh counter `rcnt`:
  - counts 0..REFRESH_DIV-1, then wraps to 0;
  - on wrap, the digit-select FSM toggles.
- Digit-select FSM has two states:
  - UNITS: drives disp[3:0], enable on an[0];
  - TENS: drives disp[7:4], enable on an[1];
  - transitions: UNITS→TENS and TENS→UNITS, each on a counter wrap only.
- Ghost guard: while rcnt==0, an=2'b11 (both digits off); seg carries the new digit's pattern.
- Decode, per standard seven-segment glyphs:
  - 0–9 map to their glyphs;
  - nibble values 10–15 map to all segments off (blank).
- err = (disp[7:4]>9) | (disp[3:0]>9), registered.
  - err tracks the held word; a later load of a valid word clears it.
- Reset mid-scan:
  - returns immediately to the reset state;
  - disp is cleared, so the pre-reset value is never re-displayed.
- Simultaneous load and counter wrap:
  - both take effect on the same edge;
  - the new slot shows the newly loaded nibble.

## Timing
- Reset values:
  - disp=8'h00, rcnt=0, state=UNITS;
  - an=2'b11, seg=all-off (7'h7F if SEG_ACTIVE_LOW, else 7'h00), err=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Load at edge k:
  - disp is updated at edge k;
  - seg and err reflect the new value from edge k+1.
- Per slot:
  - 1 guard cycle, then REFRESH_DIV-1 active cycles;
  - the full two-digit frame is 2·REFRESH_DIV cycles.
- First active enable after reset:
  - an=2'b10 from edge 2 onward (rcnt=1 reached at edge 1, registered to the output at edge 2).

## Configuration
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - in the TENS state, if disp[7:4]==0, an[1] stays 1 for the whole slot;
  - the value "07" therefore displays as " 7";
  - err is unaffected.
- Undefined: a tens nibble of 0 displays the glyph "0" normally.

## Structure
- Shared package `bcd_disp_pkg` holds:
  - the state enum (UNITS, TENS);
  - the segment glyph constants SEG_0..SEG_9 and SEG_BLANK, stored active-high;
  - the localparam for counter width, $clog2(REFRESH_DIV).
- Sub-module `bcd_to_seg`:
  - purely combinational decoder;
  - 4-bit nibble → 7-bit active-high segments, plus an invalid flag;
  - the top applies the SEG_ACTIVE_LOW inversion and the output registers.

## Test plan
Run all scenarios with REFRESH_DIV=4 and SEG_ACTIVE_LOW=1.
- Reset, then idle:
  - during reset: an=2'b11, seg=7'h7F, err=0;
  - then an alternates 11,10,10,10,11,01,01,01 per 4-cycle slot, with seg=7'h40 (glyph "0") during active cycles;
  - under LEADING_ZERO_BLANK_EN, the tens slot instead shows an=2'b11.
- Load 8'h15 (15 from the converter):
  - units slot: an=2'b10, seg=7'h12 ("5");
  - tens slot: an=2'b01, seg=7'h79 ("1").
- Load 8'h1F:
  - err=1 one cycle after the load;
  - units slot seg=7'h7F (blank);
  - then load 8'h09 → err=0 one cycle after.
- Load asserted on the same edge as a UNITS→TENS wrap, with 8'h12 replacing 8'h03:
  - the next tens slot shows "1" (7'h79), never "0".
- Assert rst_n=0 mid-slot while showing 8'h14:
  - outputs are at reset values asynchronously;
  - after release, the display shows "00", not "14".
